chunked_add_sub: RTL and testbench



---
 rtl/chunked_add_sub_pkg.sv | 20 ++
 rtl/chunked_add_sub_chunk_adder.sv | 32 +++
 rtl/chunked_add_sub.sv | 135 +++++++++++++
 tb/tb_chunked_add_sub.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/chunked_add_sub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding and
// helpers that derive the chunk count and chunk-index width from the parameters.
package chunked_add_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int calc_idx_w(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunked_add_sub_chunk_adder.sv
// Combinational CHUNK-bit ripple full adder; also exposes the carry into its
// top bit so the parent can derive signed overflow on the MSB slice.
module chunk_adder
    import chunked_add_sub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co       = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle WIDTH-bit add/subtract: one shared CHUNK-bit adder walks the
// operands low chunk first through a registered carry, with a start/done handshake.
module chunked_add_sub
    import chunked_add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(WIDTH, CHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;

    logic [CHUNK-1:0] x_sel, y_sel, s_chunk;
    logic             co_chunk, c_msb;

    // Operand slice mux for the shared adder, selected by the chunk index.
    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                x_sel = a_q[i*CHUNK +: CHUNK];
                y_sel = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk_adder (
        .x        (x_sel),
        .y        (y_sel),
        .ci       (carry_q),
        .s        (s_chunk),
        .co       (co_chunk),
        .c_msb_in (c_msb)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1; cin only matters in add mode.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = s_chunk;
                    end
                end
                carry_d = co_chunk;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = co_chunk;
                    ovf_d   = c_msb ^ co_chunk;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Drives four chunked_add_sub instances (CHUNK 4, 1, 8, 16 at WIDTH 16) with shared
// stimulus and compares each against a plain-arithmetic reference model.
module tb_chunked_add_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic [3:0]  busy_v, done_v, cout_v, ovf_v;
    logic [15:0] sum_v [4];

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    chunked_add_sub #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
    chunked_add_sub #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
    chunked_add_sub #(.WIDTH(16), .CHUNK(8)) u_c8 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));
    chunked_add_sub #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[3]), .done(done_v[3]), .sum(sum_v[3]), .cout(cout_v[3]), .ovf(ovf_v[3]));

    function automatic int chunk_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            default: return 16;
        endcase
    endfunction

    // Reference: {ovf, cout, sum} from whole-word arithmetic and the sign rule.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        logic [15:0] bb;
        logic [16:0] r;
        logic        v;
        bb = msub ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, bb} + {16'd0, (msub ? 1'b1 : mcin)};
        v  = (ma[15] == bb[15]) && (r[15] != ma[15]);
        return {v, r[16], r[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tcin, input logic tsub, input bit interfere);
        logic [17:0] exp;
        int          lat [4];
        bit          all_seen;
        exp = model(ta, tb_v, tcin, tsub);
        for (int i = 0; i < 4; i++) lat[i] = -1;
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (interfere) begin
            start = 1'b1;
            a = 16'($urandom);
            b = 16'($urandom);
            sub = ~tsub;
            cin = ~tcin;
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                check("busy_in_run", 32'(busy_v[0]), 32'd1);
                start = 1'b0;
            end
            for (int i = 0; i < 4; i++) if (done_v[i] && lat[i] < 0) lat[i] = cyc;
            all_seen = 1'b1;
            for (int i = 0; i < 4; i++) if (lat[i] < 0) all_seen = 1'b0;
            if (all_seen) break;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("latency_c%0d", chunk_of(i)), 32'(lat[i]), 32'(16 / chunk_of(i)));
            check($sformatf("sum_c%0d a=%h b=%h s=%0d", chunk_of(i), ta, tb_v, tsub),
                  32'(sum_v[i]), 32'(exp[15:0]));
            check($sformatf("cout_c%0d a=%h b=%h s=%0d", chunk_of(i), ta, tb_v, tsub),
                  32'(cout_v[i]), 32'(exp[16]));
            check($sformatf("ovf_c%0d a=%h b=%h s=%0d", chunk_of(i), ta, tb_v, tsub),
                  32'(ovf_v[i]), 32'(exp[17]));
        end
    endtask

    initial begin
        logic [17:0] e1, e2;
        int          first_done, second_done, done_seen;

        // Reset state.
        #12;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_busy_c%0d", chunk_of(i)), 32'(busy_v[i]), 32'd0);
            check($sformatf("rst_done_c%0d", chunk_of(i)), 32'(done_v[i]), 32'd0);
            check($sformatf("rst_sum_c%0d", chunk_of(i)), 32'(sum_v[i]), 32'd0);
            check($sformatf("rst_flags_c%0d", chunk_of(i)), 32'({cout_v[i], ovf_v[i]}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors, all four chunk widths in parallel.
        run_op(16'h0001, 16'h000D, 1'b1, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Start and operand changes during RUN must not disturb the result.
        run_op(16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b1);
        run_op(16'hA5A5, 16'h5A5B, 1'b1, 1'b1, 1'b1);

        // Randomized operations.
        for (int n = 0; n < 24; n++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        // Back-to-back: start held high through DONE on the CHUNK=4 instance.
        e1 = model(16'h1111, 16'h2222, 1'b1, 1'b0);
        e2 = model(16'h0100, 16'h0200, 1'b0, 1'b1);
        first_done  = -1;
        second_done = -1;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b1; sub = 1'b0; start = 1'b1;
        for (int cyc = 0; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) begin
                if (first_done < 0) begin
                    first_done = cyc;
                    check("b2b_sum1", 32'(sum_v[0]), 32'(e1[15:0]));
                    check("b2b_flags1", 32'({ovf_v[0], cout_v[0]}), 32'(e1[17:16]));
                    a = 16'h0100; b = 16'h0200; cin = 1'b0; sub = 1'b1;
                end else begin
                    second_done = cyc;
                    check("b2b_sum2", 32'(sum_v[0]), 32'(e2[15:0]));
                    check("b2b_flags2", 32'({ovf_v[0], cout_v[0]}), 32'(e2[17:16]));
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_first_latency", 32'(first_done), 32'd4);
        check("b2b_done_spacing", 32'(second_done - first_done), 32'd5);
        repeat (20) @(posedge clk);

        // Reset two cycles into an operation aborts with no done pulse.
        @(negedge clk);
        a = 16'h4321; b = 16'h1234; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abort_busy_c%0d", chunk_of(i)), 32'(busy_v[i]), 32'd0);
            check($sformatf("abort_done_c%0d", chunk_of(i)), 32'(done_v[i]), 32'd0);
            check($sformatf("abort_sum_c%0d", chunk_of(i)), 32'(sum_v[i]), 32'd0);
            check($sformatf("abort_flags_c%0d", chunk_of(i)), 32'({cout_v[i], ovf_v[i]}), 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk);
            #1;
            if (done_v != 4'b0) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run_op(16'h4321, 16'h1234, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
